casez_match_pipe: RTL and testbench

CASEZ_MATCH_PIPE -- requirements
Module: casez_match_pipe

---
 rtl/casez_match_pipe.sv | 151 +++++++++++++++
 tb/tb_casez_match_pipe.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/casez_match_pipe.sv
// casez_match_pipe
//   Two-register pipeline that builds a key from two operands and looks it up
//   in a small programmable table of wildcard patterns.
//   Stage 1 captures key = f(in_a, in_b, in_op) when the input handshake fires.
//   Stage 2 compares the stage-1 key against every enabled entry. The lowest
//   matching index wins, and the output registers are loaded from it.
//   On a miss, result and hit_idx keep their previous values and hit drops.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   cfg_we            table write strobe
//   cfg_idx           entry to write (writes to indexes >= ENTRIES are ignored)
//   cfg_val           pattern value
//   cfg_care          care mask (1 = compare this bit, 0 = don't care)
//   cfg_res           result code for the entry
//   cfg_en            entry enable
//   in_valid/in_ready input handshake
//   in_a/in_b/in_op   operands and combine mode (00 and, 01 or, 10 xor, 11 a)
//   out_valid/out_ready output handshake
//   result/hit/hit_idx registered lookup outcome
module casez_match_pipe #(
  parameter  int WIDTH   = 3,
  parameter  int ENTRIES = 4,
  parameter  int RES_W   = 3,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [WIDTH-1:0] cfg_val,
  input  logic [WIDTH-1:0] cfg_care,
  input  logic [RES_W-1:0] cfg_res,
  input  logic             cfg_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] result,
  output logic             hit,
  output logic [IDX_W-1:0] hit_idx
);

  localparam logic [IDX_W:0] ENTRIES_LIM = (IDX_W+1)'(ENTRIES);

  logic [WIDTH-1:0] tbl_val  [ENTRIES];
  logic [WIDTH-1:0] tbl_care [ENTRIES];
  logic [RES_W-1:0] tbl_res  [ENTRIES];
  logic [ENTRIES-1:0] tbl_en;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_key;
  logic [WIDTH-1:0] key_in;
  logic             s2_adv;
  logic             in_fire;
  logic             cfg_idx_ok;
  logic [ENTRIES-1:0] match;
  logic             m_hit;
  logic [IDX_W-1:0] m_idx;
  logic [RES_W-1:0] m_res;

  // The output register can take a new value when it is empty or being consumed.
  assign s2_adv     = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s2_adv;
  assign in_fire    = in_valid && in_ready;
  assign cfg_idx_ok = ({1'b0, cfg_idx} < ENTRIES_LIM);

  // Combine the operands into the lookup key.
  always_comb begin
    key_in = in_a;
    case (in_op)
      2'b00:   key_in = in_a & in_b;
      2'b01:   key_in = in_a | in_b;
      2'b10:   key_in = in_a ^ in_b;
      2'b11:   key_in = in_a;
      default: key_in = in_a;
    endcase
  end

  // Wildcard compare of the stage-1 key against every enabled entry, followed
  // by a priority pick. The scan runs from the top index down, so the lowest
  // matching index is the last one written and therefore the one that wins.
  always_comb begin
    match = '0;
    m_hit = 1'b0;
    m_idx = '0;
    m_res = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      match[i] = tbl_en[i] && (((s1_key ^ tbl_val[i]) & tbl_care[i]) == '0);
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      m_hit = match[i] ? 1'b1        : m_hit;
      m_idx = match[i] ? IDX_W'(i)   : m_idx;
      m_res = match[i] ? tbl_res[i]  : m_res;
    end
  end

  // Pattern table. A compare on the same edge as a write sees the old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_val[i]  <= '0;
        tbl_care[i] <= '0;
        tbl_res[i]  <= '0;
      end
      tbl_en <= '0;
    end else if (cfg_we && cfg_idx_ok) begin
      tbl_val[cfg_idx]  <= cfg_val;
      tbl_care[cfg_idx] <= cfg_care;
      tbl_res[cfg_idx]  <= cfg_res;
      tbl_en[cfg_idx]   <= cfg_en;
    end
  end

  // Stage 1: capture the key. A stalled key stays here, so it is looked up
  // against the table as it stands when the key finally advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_key   <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_key   <= key_in;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: register the lookup outcome. A miss keeps result and hit_idx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      hit       <= 1'b0;
      hit_idx   <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid && m_hit) begin
        result  <= m_res;
        hit     <= 1'b1;
        hit_idx <= m_idx;
      end else if (s1_valid) begin
        hit     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_casez_match_pipe.sv
// Testbench for casez_match_pipe: directed scenarios plus randomized traffic
// checked against a table-lookup reference model.
module tb_casez_match_pipe;
  localparam int W = 3;
  localparam int E = 4;
  localparam int R = 3;
  localparam int I = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_we;
  logic [I-1:0] cfg_idx;
  logic [W-1:0] cfg_val, cfg_care;
  logic [R-1:0] cfg_res;
  logic         cfg_en;
  logic         in_valid, in_ready;
  logic [W-1:0] in_a, in_b;
  logic [1:0]   in_op;
  logic         out_valid, out_ready;
  logic [R-1:0] result;
  logic         hit;
  logic [I-1:0] hit_idx;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [W-1:0] m_val [E];
  logic [W-1:0] m_care[E];
  logic [R-1:0] m_res [E];
  bit           m_en  [E];
  logic [R-1:0] last_res;
  logic [I-1:0] last_idx;

  casez_match_pipe #(.WIDTH(W), .ENTRIES(E), .RES_W(R)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_val(cfg_val), .cfg_care(cfg_care),
    .cfg_res(cfg_res), .cfg_en(cfg_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .hit(hit), .hit_idx(hit_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] calc_key(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] op);
    if (op == 2'd0)      return a & b;
    else if (op == 2'd1) return a | b;
    else if (op == 2'd2) return a ^ b;
    else                 return a;
  endfunction

  task automatic model_reset();
    for (int e = 0; e < E; e++) begin
      m_val[e] = '0; m_care[e] = '0; m_res[e] = '0; m_en[e] = 1'b0;
    end
    last_res = '0;
    last_idx = '0;
  endtask

  // lowest enabled entry whose cared-about bits all equal the key; miss keeps last
  task automatic model_lookup(input logic [W-1:0] key, output logic [R-1:0] res,
                              output logic h, output logic [I-1:0] idx);
    bit ok;
    h = 1'b0; res = last_res; idx = last_idx;
    for (int e = 0; e < E; e++) begin
      ok = m_en[e];
      for (int b = 0; b < W; b++)
        if (m_care[e][b] && (key[b] != m_val[e][b])) ok = 1'b0;
      if (ok && !h) begin
        h = 1'b1; res = m_res[e]; idx = I'(e);
      end
    end
    last_res = res;
    last_idx = idx;
  endtask

  task automatic cfg_write(input logic [I-1:0] idx, input logic [W-1:0] val,
                           input logic [W-1:0] care, input logic [R-1:0] res, input logic en);
    cfg_we = 1'b1; cfg_idx = idx; cfg_val = val; cfg_care = care; cfg_res = res; cfg_en = en;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (int'(idx) < E) begin
      m_val[idx] = val; m_care[idx] = care; m_res[idx] = res; m_en[idx] = en;
    end
  endtask

  // present one transaction with out_ready high; report out_valid after the
  // capture edge and the outputs after the second edge
  task automatic one_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                         output logic v_early, output logic v, output logic [R-1:0] r,
                         output logic h, output logic [I-1:0] idx);
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    v_early = out_valid;
    @(posedge clk); #1;
    v = out_valid; r = result; h = hit; idx = hit_idx;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_val = '0; cfg_care = '0; cfg_res = '0;
    cfg_en = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1;
    model_reset();
    #12;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (result !== 3'd0) begin n_err++; $display("FAIL rst_result got %0d want 0", result); end
    n_cmp++; if (hit !== 1'b0 || hit_idx !== 2'd0) begin n_err++; $display("FAIL rst_hit got %0b/%0d want 0/0", hit, hit_idx); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL rst_release in_ready/out_valid got %0b/%0b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_basic();
    logic ve, v, h; logic [R-1:0] r; logic [I-1:0] ix;
    cfg_write(2'd0, 3'b000, 3'b111, 3'd0, 1'b1);
    cfg_write(2'd1, 3'b001, 3'b111, 3'd1, 1'b1);
    cfg_write(2'd2, 3'b010, 3'b111, 3'd2, 1'b1);
    one_txn(3'b000, 3'b000, 2'b00, ve, v, r, h, ix);
    n_cmp++; if (ve !== 1'b0) begin n_err++; $display("FAIL lat_early out_valid got %0b want 0", ve); end
    n_cmp++; if ({v, r, h, ix} !== {1'b1, 3'd0, 1'b1, 2'd0}) begin n_err++; $display("FAIL basic_k000 got v%0b r%0d h%0b i%0d want v1 r0 h1 i0", v, r, h, ix); end
    one_txn(3'b001, 3'b011, 2'b00, ve, v, r, h, ix);
    n_cmp++; if ({v, r, h, ix} !== {1'b1, 3'd1, 1'b1, 2'd1}) begin n_err++; $display("FAIL basic_k001 got v%0b r%0d h%0b i%0d want v1 r1 h1 i1", v, r, h, ix); end
    one_txn(3'b111, 3'b011, 2'b00, ve, v, r, h, ix);
    n_cmp++; if ({v, r, h, ix} !== {1'b1, 3'd1, 1'b0, 2'd1}) begin n_err++; $display("FAIL basic_miss got v%0b r%0d h%0b i%0d want v1 r1 h0 i1", v, r, h, ix); end
  endtask

  task automatic test_priority();
    logic ve, v, h; logic [R-1:0] r; logic [I-1:0] ix;
    cfg_write(2'd3, 3'b100, 3'b100, 3'd5, 1'b1);
    one_txn(3'b110, 3'b000, 2'b11, ve, v, r, h, ix);
    n_cmp++; if ({v, r, h, ix} !== {1'b1, 3'd5, 1'b1, 2'd3}) begin n_err++; $display("FAIL prio_e3 got v%0b r%0d h%0b i%0d want v1 r5 h1 i3", v, r, h, ix); end
    cfg_write(2'd0, 3'b100, 3'b100, 3'd7, 1'b1);
    one_txn(3'b110, 3'b000, 2'b11, ve, v, r, h, ix);
    n_cmp++; if ({v, r, h, ix} !== {1'b1, 3'd7, 1'b1, 2'd0}) begin n_err++; $display("FAIL prio_e0 got v%0b r%0d h%0b i%0d want v1 r7 h1 i0", v, r, h, ix); end
    cfg_write(2'd0, 3'b000, 3'b111, 3'd0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] keys [3];
    logic [R-1:0] got_r[$];
    logic [I-1:0] got_i[$];
    int acc;
    logic rdy;
    keys[0] = 3'b000; keys[1] = 3'b001; keys[2] = 3'b010;
    acc = 0;
    out_ready = 1'b0; in_op = 2'b11; in_b = '0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (acc < 3); in_a = keys[(acc < 3) ? acc : 2];
      #1; rdy = in_ready;
      @(posedge clk); #1;
      if (rdy && in_valid) acc++;
    end
    n_cmp++; if (acc !== 2 || in_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall accepted %0d in_ready %0b want 2/0", acc, in_ready); end
    n_cmp++; if (out_valid !== 1'b1 || result !== 3'd0 || hit_idx !== 2'd0) begin n_err++; $display("FAIL bp_hold got v%0b r%0d i%0d want v1 r0 i0", out_valid, result, hit_idx); end
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (acc < 3); in_a = keys[(acc < 3) ? acc : 2];
      #1; rdy = in_ready;
      if (out_valid) begin got_r.push_back(result); got_i.push_back(hit_idx); end
      @(posedge clk); #1;
      if (rdy && in_valid) acc++;
    end
    in_valid = 1'b0;
    n_cmp++; if (got_r.size() !== 3) begin n_err++; $display("FAIL bp_count got %0d want 3", got_r.size()); end
    for (int k = 0; k < 3; k++) begin
      if (k < got_r.size()) begin
        n_cmp++; if (got_r[k] !== R'(k) || got_i[k] !== I'(k)) begin n_err++; $display("FAIL bp_order[%0d] got r%0d i%0d want r%0d i%0d", k, got_r[k], got_i[k], k, k); end
      end
    end
  endtask

  task automatic test_cfg_same_edge();
    logic ve, v, h; logic [R-1:0] r; logic [I-1:0] ix;
    out_ready = 1'b1; in_valid = 1'b1; in_a = 3'b001; in_b = '0; in_op = 2'b11;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_val = 3'b001; cfg_care = 3'b111; cfg_res = 3'd6; cfg_en = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    n_cmp++; if ({out_valid, result, hit_idx} !== {1'b1, 3'd1, 2'd1}) begin n_err++; $display("FAIL cfg_old got v%0b r%0d i%0d want v1 r1 i1", out_valid, result, hit_idx); end
    one_txn(3'b001, 3'b000, 2'b11, ve, v, r, h, ix);
    n_cmp++; if ({v, r, h, ix} !== {1'b1, 3'd6, 1'b1, 2'd1}) begin n_err++; $display("FAIL cfg_new got v%0b r%0d h%0b i%0d want v1 r6 h1 i1", v, r, h, ix); end
  endtask

  task automatic test_reset_mid();
    logic ve, v, h; logic [R-1:0] r; logic [I-1:0] ix;
    bit seen;
    out_ready = 1'b0; in_valid = 1'b1; in_a = 3'b000; in_b = '0; in_op = 2'b11;
    @(posedge clk); #1;
    in_a = 3'b001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL mid_inflight got v%0b rdy%0b want v1 rdy0", out_valid, in_ready); end
    #2; rst_n = 1'b0; #1;
    model_reset();
    n_cmp++; if ({out_valid, result, hit, hit_idx} !== {1'b0, 3'd0, 1'b0, 2'd0}) begin n_err++; $display("FAIL mid_async got v%0b r%0d h%0b i%0d want all 0", out_valid, result, hit, hit_idx); end
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL mid_post got out_valid_seen %0b rdy %0b want 0/1", seen, in_ready); end
    one_txn(3'b001, 3'b000, 2'b11, ve, v, r, h, ix);
    n_cmp++; if ({v, r, h, ix} !== {1'b1, 3'd0, 1'b0, 2'd0}) begin n_err++; $display("FAIL mid_disabled got v%0b r%0d h%0b i%0d want v1 r0 h0 i0", v, r, h, ix); end
  endtask

  task automatic test_random(input bit all_dis);
    logic [W-1:0] q[$];
    logic [R-1:0] er, pr; logic eh, ph, pv; logic [I-1:0] ei, pi;
    bit acc_in, acc_out, stall;
    int cyc, ntx;
    for (int e = 0; e < E; e++)
      cfg_write(I'(e), W'($urandom), W'($urandom), R'($urandom),
                all_dis ? 1'b0 : ($urandom_range(0, 3) != 0));
    cyc = 0; ntx = 0;
    while ((cyc < 300 || q.size() != 0) && cyc < 400) begin
      in_valid  = (cyc < 300) ? ($urandom_range(0, 3) != 0) : 1'b0;
      in_a = W'($urandom); in_b = W'($urandom); in_op = 2'($urandom);
      out_ready = (cyc < 300) ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      acc_in  = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      stall   = out_valid && !out_ready;
      pv = out_valid; pr = result; ph = hit; pi = hit_idx;
      if (acc_out) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL rand_extra unexpected output r%0d want none", result);
        end else begin
          model_lookup(q.pop_front(), er, eh, ei);
          ntx++;
          if ({result, hit, hit_idx} !== {er, eh, ei}) begin
            n_err++; $display("FAIL rand_out[%0d] got r%0d h%0b i%0d want r%0d h%0b i%0d", ntx, result, hit, hit_idx, er, eh, ei);
          end
        end
      end
      if (acc_in) q.push_back(calc_key(in_a, in_b, in_op));
      @(posedge clk); #1;
      if (stall) begin
        n_cmp++;
        if ({out_valid, result, hit, hit_idx} !== {pv, pr, ph, pi}) begin
          n_err++; $display("FAIL rand_stall got v%0b r%0d h%0b i%0d want v%0b r%0d h%0b i%0d", out_valid, result, hit, hit_idx, pv, pr, ph, pi);
        end
      end
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL rand_drain pending %0d want 0", q.size()); end
    n_cmp++; if (ntx < 50) begin n_err++; $display("FAIL rand_throughput completed %0d want >= 50", ntx); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_back_to_back();
    test_cfg_same_edge();
    test_reset_mid();
    test_random(1'b0);
    test_random(1'b1);
    test_random(1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
